shift_add_mult_ctrl: RTL
========================

// Module: shift_add_mult_ctrl
// PURPOSE
//   Sequencer for a WIDTH-bit ripple-carry adder datapath that forms an unsigned
//   WIDTH x WIDTH product by iterated add-and-shift, one adder pass per cycle.
//   Sits between switch/register operand sources and the product display, with
//   a start/done handshake. The adder is built from full-adder cells internally.
// PARAMETERS
//   WIDTH    4    operand width in bits; product is 2*WIDTH bits
// PORTS
//   clock    in   1          system clock, all state changes on rising edge
//   reset    in   1          asynchronous, active-high; clears all state
//   start    in   1          request to multiply; sampled only in IDLE
//   a        in   WIDTH      multiplicand, latched on accepted start
//   b        in   WIDTH      multiplier, latched on accepted start
//   busy     out  1          1 while in CALC
//   done     out  1          one-cycle pulse, 1 while in DONE
//   product  out  2*WIDTH    result; valid from done until next accepted start
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, busy=0, done=0, product=0, count=0,
//     internal operand regs=0. Reset mid-CALC aborts; partial result is discarded.
//   Registers: mcand[WIDTH], acc[2*WIDTH] = {hi, lo}, count[clog2(WIDTH)+1].
//   IDLE: on edge with start=1 -> mcand<=a, acc<={0, b}, count<=0, state<=CALC.
//     start=0 -> remain IDLE, product holds last value.
//   CALC (one iteration per edge):
//     sum[WIDTH:0] = hi + (lo[0] ? mcand : 0), carry-in 0, via the adder cells.
//     acc <= {sum[WIDTH:0], lo[WIDTH-1:1]} (logical right shift by 1, adder
//     carry-out enters the MSB); count <= count+1.
//     On the edge where count==WIDTH-1 (final iteration): product <= shifted acc,
//     state<=DONE.
//   DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
//   Latency: start accepted at edge k -> busy=1 in cycles k..k+WIDTH-1,
//     done=1 in cycle k+WIDTH (after edge k+WIDTH), product valid from that edge.
//   start in CALC or DONE is ignored (not queued); a,b changes after the
//     accepting edge have no effect on the current operation.
//   busy and done are never 1 simultaneously; both are decoded from state.
//   Arithmetic: unsigned only; 2*WIDTH result never overflows; the carry-out of
//     each adder pass is retained (never dropped).
//   product changes only on the final CALC edge or on reset.
//   Unused state encodings recover to IDLE on the next edge.
// TESTING
//   1) reset, a=0,b=0,start 1 cycle -> done after 4 busy cycles, product=8'h00.
//   2) a=4'hF,b=4'hF -> product=8'hE1 (225); checks carry-out on every pass.
//   3) a=7,b=5 -> product=8'h23; busy high exactly 4 cycles, done 1 cycle.
//   4) start held high through CALC/DONE with a,b changed mid-op -> first result
//      unaffected (e.g. 3x6=8'h12), next op begins only after return to IDLE.
//   5) reset asserted in 2nd CALC cycle -> immediately busy=0,done=0,product=0;
//      after release, new 9x9 -> 8'h51.
//   6) exhaustive 256 operand pairs back-to-back vs a*b reference model.

Source files
------------

// File: rtl/shift_add_mult_ctrl_if.sv
// Purpose: start/done handshake and operand/result bundle for shift_add_mult_ctrl.
// Ports (modport view):
//   master: drives start, a, b; observes busy, done, product
//   slave : observes start, a, b; drives busy, done, product
interface shift_add_mult_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// Purpose: sequencer for a ripple-carry adder datapath that forms an unsigned
//   WIDTH x WIDTH product by iterated add-and-shift, one adder pass per cycle.
// Ports:
//   clock   in  system clock, rising edge
//   reset   in  asynchronous active-high reset, clears all state
//   bus     slave modport: start/a/b in, busy/done/product out
//           busy = 1 while in CALC, done = 1 for the single DONE cycle,
//           product valid from done until the next accepted start
module shift_add_mult_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    shift_add_mult_ctrl_if.slave   bus
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PW-1:0]      product_q, product_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Ripple-carry adder: hi half of the accumulator plus the gated multiplicand.
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     carry;
    logic [WIDTH:0]     sum;

    assign hi       = acc_q[PW-1:WIDTH];
    assign addend   = acc_q[0] ? mcand_q : '0;
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        // One full-adder cell per bit.
        assign sum[i]     = hi[i] ^ addend[i] ^ carry[i];
        assign carry[i+1] = (hi[i] & addend[i]) | (carry[i] & (hi[i] ^ addend[i]));
    end

    // Carry-out becomes the top bit so no pass ever loses it.
    assign sum[WIDTH] = carry[WIDTH];

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d = bus.a;
                    acc_d   = {WIDTH'(0), bus.b};
                    count_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Add-then-shift: lo[0] selects the addend, then shift right by one.
                acc_d   = {sum, acc_q[WIDTH-1:1]};
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    product_d = acc_d;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flags are registered copies of the next-state decode so they track state exactly.
        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule
